// File: rtl/dtw_traceback.sv
// dtw_traceback
//   Path-code store and traceback walker for the DTW PE array.
//   Codes are written per cell {i,j}. On start, the walker goes backwards from (end_i,end_j)
//   to (0,0) and streams one coordinate per valid/ready handshake.
//   Optional build macro: TB_PATHLEN_EN adds the path_len output (handshake counter).
module dtw_traceback #(
    parameter int IDX_W = 5,
    parameter int N_MAX = (1 << IDX_W)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_i,
    input  logic [IDX_W-1:0] wr_j,
    input  logic [1:0]       wr_path,
    input  logic             start,
    input  logic [IDX_W-1:0] end_i,
    input  logic [IDX_W-1:0] end_j,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_i,
    output logic [IDX_W-1:0] out_j,
    output logic             out_last,
    output logic             done,
    output logic             err
`ifdef TB_PATHLEN_EN
    ,
    output logic [IDX_W+1:0] path_len
`endif
);

    localparam int DEPTH = N_MAX * N_MAX;
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;

    logic [1:0]       mem [0:DEPTH-1];
    logic [1:0]       rd_code_r;
    logic [IDX_W-1:0] cur_i_r;
    logic [IDX_W-1:0] cur_j_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;

    logic [IDX_W-1:0] next_i_s;
    logic [IDX_W-1:0] next_j_s;
    logic             last_s;
    logic             bad_s;
    logic             hs_s;

`ifdef TB_PATHLEN_EN
    logic [IDX_W+1:0] path_len_r;
`endif

    assign hs_s = out_valid_r & out_ready;

    // Path RAM write port; writes are only taken while the walker is idle.
    always_ff @(posedge clk) begin
        if (wr_en && (state_r == ST_IDLE)) begin
            mem[{wr_i, wr_j}] <= wr_path;
        end
    end

    // Next-cell selection for the current coordinate: edges are forced, interior follows the code.
    always_comb begin
        next_i_s = cur_i_r;
        next_j_s = cur_j_r;
        last_s   = 1'b0;
        bad_s    = 1'b0;
        if ((cur_i_r == IDX_ZERO) && (cur_j_r == IDX_ZERO)) begin
            last_s = 1'b1;
        end else if (cur_i_r == IDX_ZERO) begin
            next_j_s = cur_j_r - IDX_ONE;
        end else if (cur_j_r == IDX_ZERO) begin
            next_i_s = cur_i_r - IDX_ONE;
        end else begin
            case (rd_code_r)
                2'b11: begin
                    next_i_s = cur_i_r - IDX_ONE;
                    next_j_s = cur_j_r - IDX_ONE;
                end
                2'b10: begin
                    next_i_s = cur_i_r - IDX_ONE;
                end
                2'b01: begin
                    next_j_s = cur_j_r - IDX_ONE;
                end
                default: begin
                    bad_s  = 1'b1;
                    last_s = 1'b1;
                end
            endcase
        end
    end

    // Walker state register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Walker next-state logic: one RAM fetch per emitted coordinate.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_s = ST_EMIT;
            end
            ST_EMIT: begin
                if (hs_s && last_s) begin
                    state_s = ST_DONE;
                end else if (hs_s) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_EMIT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: coordinate, RAM read data, stream flags and status.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            cur_i_r     <= IDX_ZERO;
            cur_j_r     <= IDX_ZERO;
            rd_code_r   <= 2'b00;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        cur_i_r <= end_i;
                        cur_j_r <= end_j;
                        err_r   <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    rd_code_r   <= mem[{cur_i_r, cur_j_r}];
                    out_valid_r <= 1'b1;
                end
                ST_EMIT: begin
                    if (bad_s) begin
                        err_r <= 1'b1;
                    end
                    if (hs_s) begin
                        out_valid_r <= 1'b0;
                        if (last_s) begin
                            done_r <= 1'b1;
                        end else begin
                            cur_i_r <= next_i_s;
                            cur_j_r <= next_j_s;
                        end
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef TB_PATHLEN_EN
    // Path length: cleared on an accepted start, counts every output handshake.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            path_len_r <= {(IDX_W+2){1'b0}};
        end else if ((state_r == ST_IDLE) && start) begin
            path_len_r <= {(IDX_W+2){1'b0}};
        end else if ((state_r == ST_EMIT) && hs_s) begin
            path_len_r <= path_len_r + {{(IDX_W+1){1'b0}}, 1'b1};
        end else begin
            path_len_r <= path_len_r;
        end
    end

    assign path_len = path_len_r;
`endif

    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign out_i     = cur_i_r;
    assign out_j     = cur_j_r;
    assign out_last  = out_valid_r & last_s;
    assign done      = done_r;
    assign err       = err_r;

endmodule
